// File: rtl/spi_adc_scanner.sv
// rtl/spi_adc_scanner.sv - periodic masked ADC channel scanner driving an SPI master, with per-channel result bank
module spi_adc_scanner #(
    parameter int             W         = 10,
    parameter int             N_CH      = 8,
    parameter int             CH_SHIFT  = 6,
    parameter logic [W-1:0]   CMD_BASE  = 10'h200,
    parameter int             PIPE      = 1,
    parameter int             TO_CYCLES = 65535
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [N_CH-1:0]         ch_mask,
    input  logic [23:0]             scan_period,
    output logic [W-1:0]            spi_value,
    output logic                    spi_strob,
    input  logic [W-1:0]            spi_result,
    input  logic                    spi_finish,
    input  logic [$clog2(N_CH)-1:0] rd_addr,
    output logic [W-1:0]            rd_data,
    output logic [N_CH-1:0]         valid,
    output logic                    scan_done,
    output logic                    timeout_err
);
    localparam int CW = $clog2(N_CH);
    localparam int TW = $clog2(TO_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TO_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT_BUSY, WAIT_DONE, STORE, DONE} state_t;
    state_t state, state_n;

    logic [23:0]     per_cnt;
    logic [N_CH-1:0] pend;
    logic [CW-1:0]   cur_ch, prev_ch, low_ch, tgt;
    logic            first, extra, start, more, to_hit, store_en;
    logic [W-1:0]    res_q;
    logic [TW-1:0]   to_cnt;
    logic [W-1:0]    bank [N_CH];

    function automatic logic [CW-1:0] lowest(input logic [N_CH-1:0] m);
        lowest = '0;
        for (int i = N_CH - 1; i >= 0; i--)
            if (m[i]) lowest = CW'(i);
    endfunction

    function automatic logic [W-1:0] cmd(input logic [CW-1:0] ch);
        logic [31:0] word;
        word = 32'(CMD_BASE) | (32'(ch) << CH_SHIFT);
        return word[W-1:0];
    endfunction

    // per_cnt holds cycles since scan start minus one, so starts land exactly scan_period apart
    assign start    = (state == IDLE) && enable && (|ch_mask) &&
                      (({1'b0, per_cnt} + 25'd1) >= {1'b0, scan_period});
    assign low_ch   = lowest(pend);
    assign more     = |pend;
    assign to_hit   = (to_cnt == TO_LAST);
    assign store_en = !((PIPE != 0) && first);
    assign tgt      = (PIPE != 0) ? prev_ch : cur_ch;
    assign rd_data  = bank[rd_addr];

    always_comb begin
        state_n   = state;
        spi_strob = 1'b0;
        scan_done = 1'b0;
        case (state)
            IDLE:      if (start) state_n = LOAD;
            LOAD:      state_n = enable ? ISSUE : IDLE;
            ISSUE: begin
                if (spi_finish) begin
                    spi_strob = 1'b1;
                    state_n   = WAIT_BUSY;
                end else if (!enable) begin
                    state_n = IDLE;
                end
            end
            WAIT_BUSY: begin
                if (!spi_finish)  state_n = WAIT_DONE;
                else if (to_hit)  state_n = IDLE;
            end
            WAIT_DONE: begin
                if (spi_finish)   state_n = STORE;
                else if (to_hit)  state_n = IDLE;
            end
            STORE: begin
                if (!enable)                            state_n = IDLE;
                else if (more || ((PIPE != 0) && !extra)) state_n = ISSUE;
                else                                    state_n = DONE;
            end
            DONE: begin
                scan_done = 1'b1;
                state_n   = IDLE;
            end
            default:   state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            per_cnt     <= '0;
            pend        <= '0;
            cur_ch      <= '0;
            prev_ch     <= '0;
            first       <= 1'b0;
            extra       <= 1'b0;
            res_q       <= '0;
            to_cnt      <= '0;
            spi_value   <= '0;
            valid       <= '0;
            timeout_err <= 1'b0;
            for (int i = 0; i < N_CH; i++) bank[i] <= '0;
        end else begin
            state <= state_n;

            if (start)                      per_cnt <= '0;
            else if (enable && !(&per_cnt)) per_cnt <= per_cnt + 24'd1;

            if ((state_n == WAIT_BUSY || state_n == WAIT_DONE) && state_n == state)
                to_cnt <= to_cnt + TW'(1);
            else
                to_cnt <= '0;

            case (state)
                IDLE: if (start) pend <= ch_mask;
                LOAD: begin
                    cur_ch       <= low_ch;
                    pend[low_ch] <= 1'b0;
                    spi_value    <= cmd(low_ch);
                    first        <= 1'b1;
                    extra        <= 1'b0;
                end
                WAIT_DONE: if (spi_finish) res_q <= spi_result;
                STORE: begin
                    if (store_en) begin
                        bank[tgt]  <= res_q;
                        valid[tgt] <= 1'b1;
                    end
                    prev_ch <= cur_ch;
                    first   <= 1'b0;
                    if (more) begin
                        cur_ch       <= low_ch;
                        pend[low_ch] <= 1'b0;
                        spi_value    <= cmd(low_ch);
                    end else begin
                        // trailing frame re-addresses the last channel to collect its result
                        extra <= 1'b1;
                    end
                end
                default: ;
            endcase

            if ((state == WAIT_BUSY || state == WAIT_DONE) && state_n == IDLE)
                timeout_err <= 1'b1;

            if (!enable) begin
                valid       <= '0;
                timeout_err <= 1'b0;
            end
        end
    end
endmodule

// File: doc/spi_adc_scanner.md
# spi_adc_scanner

Command sequencer that sits directly upstream of the team's SPI master. It periodically scans a masked set of ADC channels. For each channel it builds the command word, pulses the master's start strobe and waits for the master's `finish` handshake. It then stores the returned word in a per-channel result bank that downstream logic reads through a combinational port.

## Interface
Parameters:
- `W` = 10 — SPI word length; equals the master's `w_length`.
- `N_CH` = 8 — channel count; power of two, 2..16.
- `CH_SHIFT` = 6 — bit position of the channel index inside the command word.
- `CMD_BASE` = 10'h200 — constant bits OR-ed into every command word.
- `PIPE` = 1 — 1: response of frame k belongs to the channel of frame k-1 (ADC returns the previous conversion). 0: same-frame response.
- `TO_CYCLES` = 65535 — max clk cycles allowed in each wait state.

Ports:
- `clk` in 1 — system clock.
- `rst` in 1 — asynchronous, active-high reset.
- `enable` in 1 — scanning allowed.
- `ch_mask` in N_CH — channels to scan; sampled at scan start.
- `scan_period` in 24 — clk cycles between scan starts; 0 = back-to-back.
- `spi_value` out W — command word to the master's `value_in`.
- `spi_strob` out 1 — one-cycle start pulse to the master's `strob_in`.
- `spi_result` in W — master's `value_out`.
- `spi_finish` in 1 — master's `finish`; 1 = idle.
- `rd_addr` in log2(N_CH) — result read address.
- `rd_data` out W — result bank word at `rd_addr`; combinational.
- `valid` out N_CH — per-channel result-written flag.
- `scan_done` out 1 — one-cycle pulse at scan completion.
- `timeout_err` out 1 — sticky error flag; cleared only by `rst` or `enable` = 0.

## Operation
- Reset values: all outputs 0, result bank 0, state IDLE, period counter 0.
- Command word: `spi_value` = `CMD_BASE` | (ch << `CH_SHIFT`), truncated to W bits. It is held stable from the ISSUE cycle until the frame ends.
- Period counter: free-runs while `enable` = 1 and resets to 0 at each scan start.
- States and transitions:
  - IDLE → LOAD when `enable` = 1 and the period counter ≥ `scan_period`. If `ch_mask` = 0 at that point, stay in IDLE: no frames and no `scan_done`.
  - LOAD: latch the mask and select the lowest set channel.
  - ISSUE: drive `spi_strob` = 1 for exactly one cycle.
  - WAIT_BUSY: wait for `spi_finish` = 0.
  - WAIT_DONE: wait for `spi_finish` = 1.
  - STORE: write the result, then go to ISSUE for the next set channel, or finish the scan.
- Frame count per scan: popcount(mask) + `PIPE`. With `PIPE` = 1:
  - The first frame's response is discarded.
  - The extra final frame re-addresses the last channel; its response is stored to that channel.
- Channel order: ascending index; unmasked channels are skipped with no idle gap.
- STORE actions: write `bank[target]` ← `spi_result` and set `valid[target]`.
- Scan end: pulse `scan_done` in the cycle after the last STORE, then return to IDLE.
- Timeout: a counter resets on entry to WAIT_BUSY and on entry to WAIT_DONE. If it reaches `TO_CYCLES`:
  - set `timeout_err`;
  - abort the scan without writing the current frame;
  - return to IDLE with no `scan_done`.
- `enable` falling mid-scan: finish the current frame (including its STORE), then go to IDLE with no `scan_done`. Clear `valid` and `timeout_err` while `enable` = 0.
- `rst` mid-frame: everything returns to reset values immediately. The master is reset by the same `rst`.

## Timing
- `spi_strob` is high for exactly one cycle per frame and is never asserted while `spi_finish` = 0.
- The master lowers `finish` 2 clk cycles after the strobe. WAIT_BUSY must therefore tolerate `spi_finish` = 1 for at least 2 cycles.
- `spi_result` is sampled in the first cycle `spi_finish` is seen high in WAIT_DONE; STORE writes it on the next edge.
- Inter-frame gap: STORE → ISSUE is 1 cycle.
- `rd_data` has zero latency. A read and a write to the same address in the same cycle returns the old data.
- `valid[i]` rises in the same cycle the bank write lands.

## Test plan
- **Mask and ordering:** `ch_mask` = 8'b0000_0101, `PIPE` = 1, bench master model echoes command word + 1.
  - 3 strobes with commands 0x200, 0x280, 0x280.
  - Required: `bank[0]` = 0x281, `bank[2]` = 0x281, `valid` = 0x05, one `scan_done`.
- **No pipeline:** `PIPE` = 0, `ch_mask` = 8'h01, model returns 0x155.
  - Required: 1 strobe, `bank[0]` = 0x155, `scan_done` 1 cycle after STORE.
- **Period and empty mask:**
  - `scan_period` = 1000: strobes of the first frame of consecutive scans are exactly 1000 cycles apart.
  - `ch_mask` = 0: no strobes and no `scan_done` for 5000 cycles.
- **Timeout:** model never lowers `finish`, `TO_CYCLES` = 50.
  - Required: `timeout_err` = 1 within 52 cycles of the strobe, no bank write, no `scan_done`, FSM back in IDLE.
- **Disable mid-scan:** drop `enable` during frame 2 of 4.
  - Required: frame 2 completes and is stored, no further strobes, then `valid` and `timeout_err` clear.
- **Reset mid-frame:** assert `rst` in WAIT_DONE.
  - Required: outputs, bank and `valid` read 0 on the same cycle. The next scan starts cleanly after release.
